smi_frame_arbiter: RTL

// - Merges NumInputs SMI flit streams onto one output stream with round-robin arbitration.
// - Switches between inputs only at frame boundaries, so a granted frame is forwarded whole.
// - Sits upstream of the frame dropper / link buffer, letting several frame sources share one.

---
 rtl/smi_frame_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/smi_frame_arbiter.sv
// smi_frame_arbiter
//   Merges NumInputs SMI flit streams onto one output stream. Arbitration is
//   round-robin and happens only at frame boundaries, so a granted frame is
//   always forwarded whole. Each new grant costs one IDLE bubble cycle.
//
// Ports
//   clk, srst        clock, synchronous active-high reset
//   dataInValid      per-input flit valid
//   dataInEofc       per-input eofc, input i at [8*i+7:8*i] (0 = mid-frame)
//   dataIn           per-input flit data, input i at slice i
//   dataInStop       per-input backpressure
//   dataOutValid     output flit valid (single output register)
//   dataOutEofc      output eofc
//   dataOut          output flit data
//   dataOutStop      downstream backpressure
//   grantActive      high while a frame is locked to an input
//   grantIndex       currently or last granted input
//
// Optional feature: define SMI_FRAME_ARBITER_COUNT_EN to add
//   frameCountReset  clears all frame counters (wins over an increment)
//   frameCount       per-input 32-bit count of completed frames, slice i
module smi_frame_arbiter #(
  parameter int unsigned NumInputs     = 2,
  parameter int unsigned FlitWidth     = 8,
  parameter int unsigned PortIndexSize = (NumInputs <= 2) ? 1 : ((NumInputs <= 4) ? 2 : 3)
) (
  input  logic                             clk,
  input  logic                             srst,
  input  logic [NumInputs-1:0]             dataInValid,
  input  logic [NumInputs*8-1:0]           dataInEofc,
  input  logic [NumInputs*FlitWidth*8-1:0] dataIn,
  output logic [NumInputs-1:0]             dataInStop,
  output logic                             dataOutValid,
  output logic [7:0]                       dataOutEofc,
  output logic [FlitWidth*8-1:0]           dataOut,
  input  logic                             dataOutStop,
  output logic                             grantActive,
  output logic [PortIndexSize-1:0]         grantIndex
`ifdef SMI_FRAME_ARBITER_COUNT_EN
  ,
  input  logic                             frameCountReset,
  output logic [NumInputs*32-1:0]          frameCount
`endif
);

  localparam int unsigned DataWidth = FlitWidth * 8;
  localparam logic [PortIndexSize-1:0] LastIdx = PortIndexSize'(NumInputs - 1);

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_t;

  state_t                   state_q, state_d;
  logic [PortIndexSize-1:0] ptr_q, ptr_d;
  logic [PortIndexSize-1:0] grant_q, grant_d;
  logic                     out_valid_q, out_valid_d;
  logic [7:0]               out_eofc_q, out_eofc_d;
  logic [DataWidth-1:0]     out_data_q, out_data_d;

  logic                     out_ready;
  logic                     sel_valid;
  logic [7:0]               sel_eofc;
  logic [DataWidth-1:0]     sel_data;
  logic                     xfer;
  logic                     xfer_eof;
  logic                     found;
  int unsigned              idx;

  // Granted input's lane and the handshake on it.
  always_comb begin
    out_ready = ~out_valid_q | ~dataOutStop;
    sel_valid = dataInValid[grant_q];
    sel_eofc  = dataInEofc[32'(grant_q) * 8 +: 8];
    sel_data  = dataIn[32'(grant_q) * DataWidth +: DataWidth];
    xfer      = (state_q == ST_LOCKED) & sel_valid & out_ready;
    xfer_eof  = xfer & (sel_eofc != '0);
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    out_data_d  = out_data_q;
    out_eofc_d  = out_eofc_q;
    // Without a transfer the register empties once it can be accepted.
    out_valid_d = out_valid_q & ~out_ready;
    dataInStop  = '1;
    found       = 1'b0;
    idx         = 0;

    case (state_q)
      ST_IDLE: begin
        // Round-robin scan from ptr with wrap; first requester wins.
        for (int unsigned k = 0; k < NumInputs; k++) begin
          idx = 32'(ptr_q) + k;
          if (idx >= NumInputs) idx = idx - NumInputs;
          if (!found && dataInValid[idx]) begin
            found   = 1'b1;
            grant_d = PortIndexSize'(idx);
            state_d = ST_LOCKED;
          end
        end
      end

      ST_LOCKED: begin
        dataInStop[grant_q] = ~out_ready;
        if (xfer) begin
          out_valid_d = 1'b1;
          out_data_d  = sel_data;
          out_eofc_d  = sel_eofc;
        end
        if (xfer_eof) begin
          state_d = ST_IDLE;
          ptr_d   = (grant_q == LastIdx) ? '0 : grant_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Payload needs no reset; it is qualified by out_valid_q.
  always_ff @(posedge clk) begin
    out_data_q <= out_data_d;
    out_eofc_q <= out_eofc_d;
  end

  assign dataOutValid = out_valid_q;
  assign dataOutEofc  = out_eofc_q;
  assign dataOut      = out_data_q;
  assign grantActive  = (state_q == ST_LOCKED);
  assign grantIndex   = grant_q;

`ifdef SMI_FRAME_ARBITER_COUNT_EN
  logic [NumInputs*32-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (frameCountReset) begin
      count_d = '0;
    end else if (xfer_eof) begin
      count_d[32'(grant_q) * 32 +: 32] = count_q[32'(grant_q) * 32 +: 32] + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign frameCount = count_q;
`endif

endmodule
